// File: rtl/adc_spi_readback.sv
// ADC serial-port register readback: shifts an 8-bit address out on sdat and captures the 8-bit reply from sdout.
// Define ADC_RB_AUTO_READOUT_EN to wrap each read in READOUT set/clear frames (F0/F1/F2 separated by GAP).
module adc_spi_readback #(
    parameter int HALF = 32,
    parameter int GAP  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] rd_addr,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sen,
    output logic       sclk,
    output logic       sdat,
    input  logic       sdout
);

    if (HALF < 2) begin : g_bad_half
        $error("adc_spi_readback: HALF must be at least 2");
    end
    if (GAP < 1) begin : g_bad_gap
        $error("adc_spi_readback: GAP must be at least 1");
    end

    localparam int CW = $clog2(2 * HALF);
    localparam logic [CW-1:0] HALF_C = CW'(HALF);
    localparam logic [CW-1:0] LAST_C = CW'(2 * HALF - 1);

`ifdef ADC_RB_AUTO_READOUT_EN
    localparam int GW = $clog2(GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_GAP   = 2'd2,
        S_FIN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_FIN   = 2'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic [3:0]      bit_q, bit_d;
`ifdef ADC_RB_AUTO_READOUT_EN
    logic [1:0]      frame_q, frame_d;
    logic [GW-1:0]   gap_q, gap_d;
`endif
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      cap_q, cap_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sen_q, sen_d;
    logic            sclk_q, sclk_d;
    logic            sdat_q, sdat_d;
    logic [15:0]     word_d;
    logic            last_cyc;
    logic            last_frame;
    logic            is_read;

    assign last_cyc = (cyc_q == LAST_C);

`ifdef ADC_RB_AUTO_READOUT_EN
    assign last_frame = (frame_q == 2'd2);
    assign is_read    = (frame_q == 2'd1);
`else
    assign last_frame = 1'b1;
    assign is_read    = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            bit_q     <= '0;
`ifdef ADC_RB_AUTO_READOUT_EN
            frame_q   <= '0;
            gap_q     <= '0;
`endif
            addr_q    <= '0;
            cap_q     <= '0;
            rd_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sen_q     <= 1'b1;
            sclk_q    <= 1'b1;
            sdat_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            bit_q     <= bit_d;
`ifdef ADC_RB_AUTO_READOUT_EN
            frame_q   <= frame_d;
            gap_q     <= gap_d;
`endif
            addr_q    <= addr_d;
            cap_q     <= cap_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sen_q     <= sen_d;
            sclk_q    <= sclk_d;
            sdat_q    <= sdat_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
`ifdef ADC_RB_AUTO_READOUT_EN
        frame_d = frame_q;
        gap_d   = gap_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_FRAME;
                    cyc_d   = '0;
                    bit_d   = '0;
`ifdef ADC_RB_AUTO_READOUT_EN
                    frame_d = '0;
`endif
                end
            end
            S_FRAME: begin
                if (last_cyc) begin
                    cyc_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
`ifdef ADC_RB_AUTO_READOUT_EN
                        if (last_frame) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
`else
                        state_d = last_frame ? S_FIN : S_IDLE;
`endif
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
`ifdef ADC_RB_AUTO_READOUT_EN
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_FRAME;
                    frame_d = frame_q + 2'd1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin values are computed for the upcoming cycle and registered, so req/sdout never reach a pin combinationally.
    always_comb begin
        addr_d = addr_q;
        if (state_q == S_IDLE && req) begin
            addr_d = rd_addr;
        end

        cap_d = cap_q;
        if (state_q == S_FRAME && is_read && bit_q[3] && last_cyc) begin
            cap_d = {cap_q[6:0], sdout};
        end

`ifdef ADC_RB_AUTO_READOUT_EN
        case (frame_d)
            2'd0:    word_d = 16'h0001;
            2'd1:    word_d = {addr_d, 8'h00};
            default: word_d = 16'h0000;
        endcase
        busy_d = (state_d == S_FRAME) || (state_d == S_GAP);
`else
        word_d = {addr_d, 8'h00};
        busy_d = (state_d == S_FRAME);
`endif

        sen_d     = (state_d != S_FRAME);
        sclk_d    = (state_d == S_FRAME) ? (cyc_d >= HALF_C) : 1'b1;
        sdat_d    = (state_d == S_FRAME) ? word_d[4'd15 - bit_d] : 1'b0;
        done_d    = (state_d == S_FIN);
        rd_data_d = (state_d == S_FIN) ? cap_d : rd_data_q;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign sen     = sen_q;
    assign sclk    = sclk_q;
    assign sdat    = sdat_q;

endmodule

// File: tb/tb_adc_spi_readback.sv
// Self-checking bench for adc_spi_readback: a timeline model of the serial transaction, a reply-driving ADC model,
// per-cycle pin comparison, and directed/random reads. Honours ADC_RB_AUTO_READOUT_EN like the design.
`timescale 1ns/1ps
module tb_adc_spi_readback;

    localparam int HALF      = 2;
    localparam int GAP       = 4;
    localparam int BIT_LEN   = 2 * HALF;
    localparam int FRAME_LEN = 16 * BIT_LEN;
`ifdef ADC_RB_AUTO_READOUT_EN
    localparam int NF        = 3;
    localparam int RD_FRAME  = 1;
    localparam int LAT       = 3 * FRAME_LEN + 2 * GAP + 1;
    localparam int LAT_LIT   = 201;
`else
    localparam int NF        = 1;
    localparam int RD_FRAME  = 0;
    localparam int LAT       = FRAME_LEN + 1;
    localparam int LAT_LIT   = 65;
`endif
    localparam int RST_AT    = 1 + RD_FRAME * (FRAME_LEN + GAP) + FRAME_LEN / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic       sdout = 1'b0;
    logic       busy, done, sen, sclk, sdat;
    logic [7:0] rd_data;

    adc_spi_readback #(.HALF(HALF), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .sen     (sen),
        .sclk    (sclk),
        .sdat    (sdat),
        .sdout   (sdout)
    );

    always #25 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // What the ADC must see on sdat for frame f of a read of address a.
    function automatic logic [15:0] word_of(input int f, input logic [7:0] a);
`ifdef ADC_RB_AUTO_READOUT_EN
        if (f == 0) return 16'h0001;
        if (f == 1) return {a, 8'h00};
        return 16'h0000;
`else
        return {a, 8'h00};
`endif
    endfunction

    // Transaction model: m_t is the cycle number since acceptance (1..LAT while active).
    bit         m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_addr = 8'h00;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rd = 8'h00;
    logic [7:0] adc_val = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
            m_rd     = 8'h00;
        end else if (m_active) begin
            m_t++;
            if (m_t == LAT) m_rd = m_data;
            if (m_t > LAT) m_active = 1'b0;
        end else if (req) begin
            m_active = 1'b1;
            m_t      = 1;
            m_addr   = rd_addr;
            m_data   = adc_val;
        end
    end

    logic e_sen, e_sclk, e_sdat, e_busy, e_done;

    task automatic model_pins(input bit act, input int t, input logic [7:0] a);
        logic [15:0] w;
        int s, idx;
        e_sen = 1'b1; e_sclk = 1'b1; e_sdat = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (act) begin
            if (t == LAT) begin
                e_done = 1'b1;
            end else begin
                e_busy = 1'b1;
                for (int f = 0; f < NF; f++) begin
                    s = 1 + f * (FRAME_LEN + GAP);
                    if (t >= s && t < s + FRAME_LEN) begin
                        idx    = t - s;
                        w      = word_of(f, a);
                        e_sen  = 1'b0;
                        e_sclk = ((idx % BIT_LEN) >= HALF);
                        e_sdat = w[15 - idx / BIT_LEN];
                    end
                end
            end
        end
    endtask

    // Pin observation: frames as the ADC latches them on sclk rising edges.
    logic [15:0] frames[$];
    int          lens[$];
    int          starts[$];
    int          done_cnt = 0;
    int          cyc_cnt = 0;
    logic        prev_sen = 1'b1;
    logic        prev_sclk = 1'b1;
    logic [15:0] cur_word = 16'h0;
    int          cur_len = 0;

    initial begin
        int idx, b, c;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            // ADC reply: the correct bit only on the last cycle of each data bit, its inverse elsewhere.
            sdout = 1'($urandom);
            if (m_active) begin
                idx = m_t - (1 + RD_FRAME * (FRAME_LEN + GAP));
                if (idx >= 0 && idx < FRAME_LEN) begin
                    b = idx / BIT_LEN;
                    c = idx % BIT_LEN;
                    if (b >= 8) sdout = (c == BIT_LEN - 1) ? m_data[15 - b] : ~m_data[15 - b];
                end
            end

            model_pins(m_active, m_t, m_addr);
            check("sen", sen, e_sen);
            check("sclk", sclk, e_sclk);
            check("sdat", sdat, e_sdat);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("rd_data", rd_data, m_rd);

            if (rst) begin
                prev_sen  = 1'b1;
                prev_sclk = 1'b1;
            end else begin
                if (done === 1'b1) done_cnt++;
                if (sen === 1'b0) begin
                    if (prev_sen) begin
                        starts.push_back(cyc_cnt);
                        cur_len  = 0;
                        cur_word = 16'h0;
                    end
                    cur_len++;
                    if (sclk && !prev_sclk) cur_word = {cur_word[14:0], sdat};
                end else if (!prev_sen) begin
                    frames.push_back(cur_word);
                    lens.push_back(cur_len);
                end
                prev_sen  = sen;
                prev_sclk = sclk;
            end
        end
    end

    // Issue a read at the current negedge and wait for done; an optional stray req (rd_addr 8'h25) at cycle stray_at.
    task automatic do_read(input logic [7:0] a, input logic [7:0] v, input int stray_at,
                           input string tag, output int lat);
        bit ok;
        int done0;
        frames.delete();
        lens.delete();
        starts.delete();
        done0   = done_cnt;
        rd_addr = a;
        adc_val = v;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < LAT + 40; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (lat == stray_at) begin
                rd_addr = 8'h25;
                req     = 1'b1;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        req = 1'b0;
        #1;
        check({tag, " done seen"}, ok, 1'b1);
        check({tag, " latency"}, lat, LAT);
        check({tag, " rd_data"}, rd_data, v);
        check({tag, " frame count"}, frames.size(), NF);
        for (int f = 0; f < NF; f++) begin
            if (f < frames.size()) check({tag, " frame word"}, frames[f], word_of(f, a));
        end
        check({tag, " single done"}, done_cnt - done0, 1);
    endtask

    initial begin
        #(50 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, done0, n, stray;
        logic [7:0] a, v;

        repeat (2) @(negedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset rd_data", rd_data, 8'h00);
        check("reset sen", sen, 1'b1);
        check("reset sclk", sclk, 1'b1);
        check("reset sdat", sdat, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef ADC_RB_AUTO_READOUT_EN
        do_read(8'h3D, 8'hE0, 0, "directed", lat);
        check("directed done cycle", lat, 201);
        check("directed rd_data literal", rd_data, 8'hE0);
        if (frames.size() == 3) begin
            check("directed F0 word", frames[0], 16'h0001);
            check("directed F1 word", frames[1], 16'h3D00);
            check("directed F2 word", frames[2], 16'h0000);
            for (int i = 0; i < 3; i++) check("directed window length", lens[i], 64);
            for (int i = 0; i < 2; i++) check("directed gap length", starts[i+1] - (starts[i] + lens[i]), 4);
        end
`else
        do_read(8'h41, 8'hC0, 0, "directed", lat);
        check("directed done cycle", lat, 65);
        check("directed rd_data literal", rd_data, 8'hC0);
        if (frames.size() == 1) begin
            check("directed frame word", frames[0], 16'h4100);
            check("directed window length", lens[0], 64);
        end
`endif
        check("latency formula", LAT, LAT_LIT);

        @(negedge clk);
        do_read(8'h0F, 8'hAA, 0, "alternating", lat);
        check("alternating rd_data literal", rd_data, 8'hAA);

        // Stray req mid-read is dropped; a req in the FIN cycle is dropped too.
        @(negedge clk);
        do_read(8'h5A, 8'h3C, 10, "stray", lat);
        if (frames.size() > RD_FRAME) check("stray read frame literal", frames[RD_FRAME], 16'h5A00);
        done0   = done_cnt;
        rd_addr = 8'h11;
        req     = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("fin req ignored busy", busy, 1'b0);
        check("fin req ignored sen", sen, 1'b1);
        check("fin req ignored done count", done_cnt, done0);

        // Asynchronous reset in the middle of the read frame.
        @(negedge clk);
        rd_addr = 8'h77;
        adc_val = 8'h96;
        req     = 1'b1;
        @(negedge clk);
        req   = 1'b0;
        done0 = done_cnt;
        for (int i = 0; i < LAT && m_t < RST_AT; i++) @(negedge clk);
        check("pre-reset in frame", sen, 1'b0);
        #5 rst = 1'b1;
        #1;
        check("async rst sen", sen, 1'b1);
        check("async rst sclk", sclk, 1'b1);
        check("async rst sdat", sdat, 1'b0);
        check("async rst busy", busy, 1'b0);
        check("async rst done", done, 1'b0);
        check("async rst rd_data", rd_data, 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("no done after reset", done_cnt, done0);
        do_read(8'h52, 8'h6B, 0, "after reset", lat);

        // Back-to-back: second req on the cycle right after done.
        @(negedge clk);
        do_read(8'h12, 8'h81, 0, "b2b first", lat);
        @(negedge clk);
        do_read(8'h34, 8'h7E, 0, "b2b second", lat);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n = $urandom_range(0, 4);
            repeat (n) @(negedge clk);
            a     = 8'($urandom);
            v     = 8'($urandom);
            stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, LAT - 2)) : 0;
            do_read(a, v, stray, "random", lat);
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
